// File: rtl/intr_req_gen_if.sv
// Core-side interrupt handshake of intr_req_gen: mask and acknowledge from the
// CPU core, request level and pending/overflow status back to it.
interface intr_req_gen_if #(
  parameter int PEND_W = 3
) ();
  logic              irq_mask;
  logic              cpu_ack;
  logic              interrupter;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    input  irq_mask,
    input  cpu_ack,
    output interrupter,
    output pending,
    output overflow
  );

  modport slave (
    output irq_mask,
    output cpu_ack,
    input  interrupter,
    input  pending,
    input  overflow
  );
endinterface

// File: rtl/intr_req_gen.sv
// Interrupt request generator: synchronises/debounces the interrupt button, counts
// presses and presents a level request to the core. Debounce filter under INTR_DEBOUNCE_EN.
module intr_req_gen #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter int PEND_W          = 3,
  parameter int GAP_CYCLES      = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           btn_raw,
  output logic           btn_clean,
  intr_req_gen_if.master core
);

  localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
      GAP_CYCLES < 1 || PEND_W < 1) begin : g_bad_params
    $error("intr_req_gen: illegal parameter combination");
  end

  logic [1:0]        sync_r;
  logic              btn_sync_s;
  logic              clean_r;
  logic              clean_d_r;
  logic              press_s;
  logic              ack_take_s;
  logic [PEND_W-1:0] pend_r;
  logic [PEND_W-1:0] pend_nxt_s;
  logic              ovf_r;
  logic              ovf_nxt_s;
  state_e            state_r;
  state_e            state_nxt_s;
  logic [GAP_W-1:0]  gap_r;
  logic [GAP_W-1:0]  gap_nxt_s;
  logic              intr_r;

  // two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

  assign btn_sync_s = sync_r[1];

`ifdef INTR_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_r;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // clean level follows only after the synchronised level disagrees for the full window
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      clean_r <= 1'b0;
    end else if (btn_sync_s == clean_r) begin
      cnt_r   <= '0;
    end else if (cnt_r == DEB_LAST) begin
      cnt_r   <= '0;
      clean_r <= btn_sync_s;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end
`else
  // filter bypassed: clean level tracks the synchroniser directly
  always_ff @(posedge clk) begin
    if (rst) begin
      clean_r <= 1'b0;
    end else begin
      clean_r <= btn_sync_s;
    end
  end
`endif

  assign press_s    = clean_r & ~clean_d_r;
  assign ack_take_s = core.cpu_ack & (state_r == ST_ASSERT);

  // pending count; a coincident press and acknowledge cancel, so overflow is not flagged
  always_comb begin
    pend_nxt_s = pend_r;
    ovf_nxt_s  = ovf_r;
    case ({press_s, ack_take_s})
      2'b10: begin
        if (pend_r == PEND_MAX) begin
          ovf_nxt_s = 1'b1;
        end else begin
          pend_nxt_s = pend_r + PEND_W'(1);
        end
      end
      2'b01:   pend_nxt_s = pend_r - PEND_W'(1);
      default: pend_nxt_s = pend_r;
    endcase
  end

  // request FSM; acknowledge wins over a mask raised in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    case (state_r)
      ST_IDLE: begin
        if ((pend_r != '0) && !core.irq_mask) begin
          state_nxt_s = ST_ASSERT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (ack_take_s) begin
          state_nxt_s = ST_GAP;
          gap_nxt_s   = '0;
        end else if (core.irq_mask) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_nxt_s = ST_IDLE;
          gap_nxt_s   = '0;
        end else begin
          gap_nxt_s   = gap_r + GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gap_nxt_s   = '0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      clean_d_r <= 1'b0;
      pend_r    <= '0;
      ovf_r     <= 1'b0;
      state_r   <= ST_IDLE;
      gap_r     <= '0;
      intr_r    <= 1'b0;
    end else begin
      clean_d_r <= clean_r;
      pend_r    <= pend_nxt_s;
      ovf_r     <= ovf_nxt_s;
      state_r   <= state_nxt_s;
      gap_r     <= gap_nxt_s;
      intr_r    <= (state_nxt_s == ST_ASSERT);
    end
  end

  assign core.interrupter = intr_r;
  assign core.pending     = pend_r;
  assign core.overflow    = ovf_r;
  assign btn_clean        = clean_r;

endmodule

// File: tb/tb_intr_req_gen.sv
// Scoreboard bench for intr_req_gen: stimulus queues timestamped output changes,
// a negedge monitor checks every observed change and the all-zero reset state.
module tb_intr_req_gen;
  localparam int DEB = 4;
  localparam int GAP = 2;
  localparam int PW  = 2;
`ifdef INTR_DEBOUNCE_EN
  localparam int CL  = DEB + 1;
`else
  localparam int CL  = 2;
`endif
  localparam logic [PW-1:0] PMAX = {PW{1'b1}};

  typedef struct {
    int            cyc;
    logic          intr;
    logic [PW-1:0] pend;
    logic          ovf;
    logic          clean;
  } ev_t;

  ev_t exp_q[$];

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic btn_raw = 1'b1;
  logic btn_clean;
  logic rst_q   = 1'b0;
  bit   armed   = 1'b0;
  logic [PW+2:0] prev = '0;
  int cyc    = 0;
  int n_vec  = 0;
  int n_fail = 0;
  int t, r, k, u;
  logic [PW-1:0] m_pend;
  logic          m_ovf;

  intr_req_gen_if #(.PEND_W(PW)) bus_if ();

  intr_req_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .PEND_W         (PW),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_clean(btn_clean),
    .core     (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expired", cyc);
    $fatal(1);
  end

  always @(negedge clk) begin
    logic [PW+2:0] cur;
    logic [PW+2:0] want;
    ev_t e;
    cur = {bus_if.interrupter, bus_if.pending, bus_if.overflow, btn_clean};
    if (rst_q) armed = 1'b1;
    if (armed) begin
      if (rst_q) begin
        n_vec++;
        if (cur !== '0) begin
          n_fail++;
          $display("FAIL reset_zero cyc=%0d got=%b want=%b", cyc, cur, {(PW+3){1'b0}});
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_fail++;
        $display("FAIL missed_change cyc=%0d want_at=%0d got=%b want=%b",
                 cyc, e.cyc, cur, {e.intr, e.pend, e.ovf, e.clean});
      end
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, cur, prev);
        end else begin
          e    = exp_q.pop_front();
          want = {e.intr, e.pend, e.ovf, e.clean};
          if (e.cyc != cyc || cur !== want) begin
            n_fail++;
            $display("FAIL output_change cyc=%0d want_at=%0d got=%b want=%b",
                     cyc, e.cyc, cur, want);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    if (e > cyc) step(e - cyc);
  endtask

  task automatic expect_ev(input int c, input logic i, input logic [PW-1:0] p,
                           input logic o, input logic b);
    ev_t e;
    e.cyc = c; e.intr = i; e.pend = p; e.ovf = o; e.clean = b;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut(input bit nz);
    rst = 1'b1;
    btn_raw = 1'b0;
    bus_if.irq_mask = 1'b0;
    bus_if.cpu_ack  = 1'b0;
    if (nz) expect_ev(cyc + 1, 1'b0, '0, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;
  endtask

  // one full press/release while masked; updates the bench model of pending/overflow
  task automatic press_masked();
    logic [PW-1:0] np;
    logic          no;
    int            ts, rs;
    ts = cyc + 1;
    btn_raw = 1'b1;
    expect_ev(ts + CL, 1'b0, m_pend, m_ovf, 1'b1);
    np = m_pend;
    no = m_ovf;
    if (m_pend == PMAX) no = 1'b1;
    else np = m_pend + 2'd1;
    if (np != m_pend || no != m_ovf) expect_ev(ts + CL + 1, 1'b0, np, no, 1'b1);
    m_pend = np;
    m_ovf  = no;
    wait_until(ts + CL + 1);
    btn_raw = 1'b0;
    rs = cyc + 1;
    expect_ev(rs + CL, 1'b0, m_pend, m_ovf, 1'b0);
    wait_until(rs + CL + 1);
  endtask

  initial begin
    bus_if.irq_mask = 1'b1;
    bus_if.cpu_ack  = 1'b0;

    // reset held 3 cycles with the button high; first free edge samples it
    step(3);
    rst = 1'b0;
    t = cyc + 1;
    expect_ev(t + CL, 1'b0, 2'd0, 1'b0, 1'b1);
    expect_ev(t + CL + 1, 1'b0, 2'd1, 1'b0, 1'b1);
    wait_until(t + CL + 3);
    reset_dut(1'b1);

    // single press, request, acknowledge, no re-assert
    t = cyc + 1;
    btn_raw = 1'b1;
    expect_ev(t + CL, 1'b0, 2'd0, 1'b0, 1'b1);
    expect_ev(t + CL + 1, 1'b0, 2'd1, 1'b0, 1'b1);
    expect_ev(t + CL + 2, 1'b1, 2'd1, 1'b0, 1'b1);
    wait_until(t + CL + 6);
    bus_if.cpu_ack = 1'b1;
    expect_ev(t + CL + 7, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1);
    bus_if.cpu_ack = 1'b0;
    step(8);
    t = cyc + 1;
    btn_raw = 1'b0;
    expect_ev(t + CL, 1'b0, 2'd0, 1'b0, 1'b0);
    wait_until(t + CL + 2);

`ifdef INTR_DEBOUNCE_EN
    // bouncing contact yields one press; a short dropout never releases
    t = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      btn_raw = (((i / 2) % 2) == 0);
      step(1);
    end
    btn_raw = 1'b1;
    u = t + 12;
    expect_ev(u + CL, 1'b0, 2'd0, 1'b0, 1'b1);
    expect_ev(u + CL + 1, 1'b0, 2'd1, 1'b0, 1'b1);
    expect_ev(u + CL + 2, 1'b1, 2'd1, 1'b0, 1'b1);
    wait_until(u + CL + 3);
    btn_raw = 1'b0;
    step(3);
    btn_raw = 1'b1;
    step(10);
    k = cyc + 1;
    bus_if.cpu_ack = 1'b1;
    expect_ev(k, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1);
    bus_if.cpu_ack = 1'b0;
    step(2);
    reset_dut(1'b1);
`endif

    // masked presses saturate pending and set overflow; unmask raises request
    bus_if.irq_mask = 1'b1;
    m_pend = '0;
    m_ovf  = 1'b0;
    repeat (4) press_masked();
    k = cyc + 1;
    bus_if.irq_mask = 1'b0;
    expect_ev(k, 1'b1, 2'd3, 1'b1, 1'b0);
    wait_until(k + 2);

    // acknowledge, gap with ignored acks, re-assert; then a plain second ack
    k = cyc + 1;
    bus_if.cpu_ack = 1'b1;
    expect_ev(k, 1'b0, 2'd2, 1'b1, 1'b0);
    expect_ev(k + GAP + 1, 1'b1, 2'd2, 1'b1, 1'b0);
    step(3);
    bus_if.cpu_ack = 1'b0;
    wait_until(k + GAP + 3);
    k = cyc + 1;
    bus_if.cpu_ack = 1'b1;
    expect_ev(k, 1'b0, 2'd1, 1'b1, 1'b0);
    expect_ev(k + GAP + 1, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1);
    bus_if.cpu_ack = 1'b0;
    wait_until(k + GAP + 3);
    reset_dut(1'b1);

    // coincident press and ack at saturation; ack beats a rising mask
    bus_if.irq_mask = 1'b1;
    m_pend = '0;
    m_ovf  = 1'b0;
    repeat (3) press_masked();
    k = cyc + 1;
    bus_if.irq_mask = 1'b0;
    expect_ev(k, 1'b1, 2'd3, 1'b0, 1'b0);
    wait_until(k + 1);
    t = cyc + 1;
    btn_raw = 1'b1;
    expect_ev(t + CL, 1'b1, 2'd3, 1'b0, 1'b1);
    wait_until(t + CL);
    bus_if.cpu_ack = 1'b1;
    expect_ev(t + CL + 1, 1'b0, 2'd3, 1'b0, 1'b1);
    expect_ev(t + CL + GAP + 2, 1'b1, 2'd3, 1'b0, 1'b1);
    step(1);
    bus_if.cpu_ack = 1'b0;
    wait_until(t + CL + GAP + 3);
    btn_raw = 1'b0;
    r = cyc + 1;
    expect_ev(r + CL, 1'b1, 2'd3, 1'b0, 1'b0);
    wait_until(r + CL + 1);
    k = cyc + 1;
    bus_if.irq_mask = 1'b1;
    bus_if.cpu_ack  = 1'b1;
    expect_ev(k, 1'b0, 2'd2, 1'b0, 1'b0);
    step(1);
    bus_if.cpu_ack = 1'b0;
    step(6);
    k = cyc + 1;
    bus_if.irq_mask = 1'b0;
    expect_ev(k, 1'b1, 2'd2, 1'b0, 1'b0);
    wait_until(k + 1);
    k = cyc + 1;
    bus_if.irq_mask = 1'b1;
    expect_ev(k, 1'b0, 2'd2, 1'b0, 1'b0);
    wait_until(k + 2);
    k = cyc + 1;
    bus_if.irq_mask = 1'b0;
    expect_ev(k, 1'b1, 2'd2, 1'b0, 1'b0);
    wait_until(k + 3);

    step(2);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_fail++;
      $display("FAIL never_seen want_at=%0d want=%b", e.cyc, {e.intr, e.pend, e.ovf, e.clean});
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
